// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice:
//   - ALU32 control codes (the arbiter passes these through untouched)
//   - FSM state encoding for the arbiter sequencer
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu32.sv
// alu32
// Combinational 32-bit ALU shared by the arbiter's clients. Lives next to
// alu_arbiter in the top level.
// Ports:
//   dataa, datab  in   operands
//   aluctr        in   control code (see alu_arbiter_pkg)
//   result        out  operation result (0 for undefined codes)
//   zero          out  result == 0
module alu32
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    input  logic [3:0]  aluctr,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (aluctr)
            ALU_ADD:  result = dataa + datab;
            ALU_SLL:  result = dataa << datab[4:0];
            ALU_SLT:  result = {31'd0, $signed(dataa) < $signed(datab)};
            ALU_SLTU: result = {31'd0, dataa < datab};
            ALU_XOR:  result = dataa ^ datab;
            ALU_SRL:  result = dataa >> datab[4:0];
            ALU_OR:   result = dataa | datab;
            ALU_AND:  result = dataa & datab;
            ALU_SUB:  result = dataa - datab;
            ALU_SRA:  result = $signed(dataa) >>> datab[4:0];
            ALU_LUI:  result = datab;
            default:  result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2
// Two-input round-robin pick. A lone valid requester always wins; when both
// are valid the pointer decides.
// Ports:
//   valid[1:0]  in   request valid per requester
//   ptr         in   favoured requester (0 or 1)
//   grant[1:0]  out  one-hot grant (all zero when nothing is valid)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU32 between two requesters. IDLE grants one request
// (round-robin), EXEC drives the ALU from registered operands and captures
// its outputs, RESP presents the result to the winner until consumed.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid_/ready_/ctr_/a_/b_*  request handshake + payload per requester
//   rsp_valid_/ready_/result_/zero_*  response handshake + captured result
//   alu_dataa/datab/aluctr         to ALU32
//   alu_result/alu_zero            from ALU32
//   busy                           high in EXEC or RESP
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid_0,
    output logic         req_ready_0,
    input  logic [3:0]   req_ctr_0,
    input  logic [N-1:0] req_a_0,
    input  logic [N-1:0] req_b_0,
    input  logic         req_valid_1,
    output logic         req_ready_1,
    input  logic [3:0]   req_ctr_1,
    input  logic [N-1:0] req_a_1,
    input  logic [N-1:0] req_b_1,
    output logic         rsp_valid_0,
    input  logic         rsp_ready_0,
    output logic [N-1:0] rsp_result_0,
    output logic         rsp_zero_0,
    output logic         rsp_valid_1,
    input  logic         rsp_ready_1,
    output logic [N-1:0] rsp_result_1,
    output logic         rsp_zero_1,
    output logic [N-1:0] alu_dataa,
    output logic [N-1:0] alu_datab,
    output logic [3:0]   alu_aluctr,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic         busy
);

    state_t       state_q, state_d;
    logic         win_q,   win_d;    // id of the requester being served
    logic         ptr_q,   ptr_d;    // favoured requester for the next tie
    logic [3:0]   ctr_q,   ctr_d;
    logic [N-1:0] a_q,     a_d;
    logic [N-1:0] b_q,     b_d;

    logic [1:0]   grant;

    rr_arb2 u_rr_arb2 (
        .valid ({req_valid_1, req_valid_0}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        ptr_d       = ptr_q;
        ctr_d       = ctr_q;
        a_d         = a_q;
        b_d         = b_q;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ready is a same-cycle function of valid so a request
                // is accepted in the cycle it is first seen
                if (grant != 2'b00) begin
                    req_ready_0 = grant[0];
                    req_ready_1 = grant[1];
                    win_d       = grant[1];
                    ctr_d       = grant[1] ? req_ctr_1 : req_ctr_0;
                    a_d         = grant[1] ? req_a_1   : req_a_0;
                    b_d         = grant[1] ? req_b_1   : req_b_0;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (win_q ? rsp_ready_1 : rsp_ready_0) begin
                    ptr_d   = ~win_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            ptr_q   <= 1'b0;
            ctr_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            ctr_q   <= ctr_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Per-requester result registers; only the current winner's pair is
    // written, so the other requester keeps its last response visible.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        localparam logic ID = (gi == 1);
        logic [N-1:0] result_q, result_d;
        logic         zero_q,   zero_d;

        always_comb begin
            result_d = result_q;
            zero_d   = zero_q;
            if (state_q == ST_EXEC && win_q == ID) begin
                result_d = alu_result;
                zero_d   = alu_zero;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                result_q <= '0;
                zero_q   <= 1'b0;
            end else begin
                result_q <= result_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign rsp_result_0 = g_rsp[0].result_q;
    assign rsp_zero_0   = g_rsp[0].zero_q;
    assign rsp_result_1 = g_rsp[1].result_q;
    assign rsp_zero_1   = g_rsp[1].zero_q;

    assign rsp_valid_0  = (state_q == ST_RESP) && !win_q;
    assign rsp_valid_1  = (state_q == ST_RESP) &&  win_q;
    assign busy         = (state_q != ST_IDLE);

    assign alu_dataa    = a_q;
    assign alu_datab    = b_q;
    assign alu_aluctr   = ctr_q;

endmodule
